// File: rtl/traceback_unit.sv
// traceback_unit
//
// Traceback engine of the local-alignment accelerator. When the controller
// pulses start_of_traceback (with en_traceback high) the unit loads the
// global max cell and walks the stored direction matrix back toward the
// origin. Each non-STOP cell visited becomes one alignment step on the
// output port. When the walk has ended and the output slot has drained,
// the unit pulses finished together with the number of emitted steps.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   en_traceback        held high by the controller for the whole traceback
//   start_of_traceback  one-cycle start pulse (honoured only in IDLE)
//   max_row/max_col     coordinates of the global max cell
//   max_score           global max score (0 means an empty path)
//   mem_dir             direction stored at (next_row,next_col), combinational
//                       from matrix memory: 00 STOP, 01 DIAG, 10 UP, 11 LEFT
//   next_row/next_col   registered current cell, decoded into memory selects
//   out_valid/out_ready step handshake
//   out_dir/out_row/out_col/out_last  step payload
//   finished            one-cycle completion pulse
//   path_len            number of emitted steps, valid while finished=1
//
// Handshake: the output is a single registered slot. A step transfers on a
// rising edge where out_valid=1 and out_ready=1. While out_valid=1 and
// out_ready=0 the whole payload is held stable. The slot may take a new step
// whenever it is empty or is being consumed in the same cycle
// (slot_free = !out_valid || out_ready).

module traceback_unit #(
    parameter int SEQ_LENGTH     = 32,
    parameter int ROW_BITS_WIDTH = 5,
    parameter int COL_BITS_WIDTH = 5,
    parameter int SCORE_W        = 8,
    parameter int PATH_LEN_W     = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_traceback,
    input  logic                      start_of_traceback,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    input  logic [SCORE_W-1:0]        max_score,
    input  logic [1:0]                mem_dir,
    output logic [ROW_BITS_WIDTH-1:0] next_row,
    output logic [COL_BITS_WIDTH-1:0] next_col,
    output logic                      finished,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_dir,
    output logic [ROW_BITS_WIDTH-1:0] out_row,
    output logic [COL_BITS_WIDTH-1:0] out_col,
    output logic                      out_last,
    output logic [PATH_LEN_W:0]       path_len
);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;

    // Longest legal path: every step removes at least one row or column.
    localparam int                    MAX_STEPS = 2 * SEQ_LENGTH - 1;
    localparam logic [PATH_LEN_W-1:0] CNT_MAX   = PATH_LEN_W'(MAX_STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state, state_nx;
    logic [PATH_LEN_W-1:0]     counter, counter_nx;
    logic [ROW_BITS_WIDTH-1:0] row_nx;
    logic [COL_BITS_WIDTH-1:0] col_nx;
    logic                      valid_nx, last_nx, finished_nx;
    logic [1:0]                dir_nx;
    logic [ROW_BITS_WIDTH-1:0] orow_nx;
    logic [COL_BITS_WIDTH-1:0] ocol_nx;
    logic [PATH_LEN_W:0]       path_len_nx;
    logic                      slot_free;
    logic                      at_edge;
    logic                      cnt_inc;

    assign slot_free = !out_valid || out_ready;

    // A DIAG/UP move needs row>0 and a DIAG/LEFT move needs col>0; otherwise
    // this step is the forced final step of the path.
    assign at_edge = ((mem_dir != DIR_LEFT) && (next_row == '0)) ||
                     ((mem_dir != DIR_UP)   && (next_col == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            counter   <= '0;
            next_row  <= '0;
            next_col  <= '0;
            out_valid <= 1'b0;
            out_dir   <= 2'b00;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            finished  <= 1'b0;
            path_len  <= '0;
        end else begin
            state     <= state_nx;
            counter   <= counter_nx;
            next_row  <= row_nx;
            next_col  <= col_nx;
            out_valid <= valid_nx;
            out_dir   <= dir_nx;
            out_row   <= orow_nx;
            out_col   <= ocol_nx;
            out_last  <= last_nx;
            finished  <= finished_nx;
            path_len  <= path_len_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        counter_nx  = counter;
        row_nx      = next_row;
        col_nx      = next_col;
        valid_nx    = out_valid;
        dir_nx      = out_dir;
        orow_nx     = out_row;
        ocol_nx     = out_col;
        last_nx     = out_last;
        finished_nx = 1'b0;
        path_len_nx = '0;
        cnt_inc     = 1'b0;

        // Slot consumed this cycle; a new load below may refill it.
        if (out_valid && out_ready) begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (start_of_traceback && en_traceback) begin
                    row_nx     = max_row;
                    col_nx     = max_col;
                    counter_nx = '0;
                    state_nx   = (max_score == '0) ? S_DONE : S_WALK;
                end
            end

            S_WALK: begin
                if (!en_traceback) begin
                    state_nx   = S_IDLE;
                    valid_nx   = 1'b0;
                    last_nx    = 1'b0;
                    counter_nx = '0;
                end else if (slot_free) begin
                    if (mem_dir == DIR_STOP) begin
                        // A step still waiting in the slot is left as is and
                        // is not marked last after the fact.
                        state_nx = S_DONE;
                    end else begin
                        valid_nx = 1'b1;
                        dir_nx   = mem_dir;
                        orow_nx  = next_row;
                        ocol_nx  = next_col;
                        cnt_inc  = 1'b1;
                        if (counter != CNT_MAX) begin
                            counter_nx = counter + PATH_LEN_W'(1);
                        end
                        if (at_edge) begin
                            last_nx  = 1'b1;
                            state_nx = S_DONE;
                        end else begin
                            last_nx = 1'b0;
                            if (mem_dir != DIR_LEFT) begin
                                row_nx = next_row - ROW_BITS_WIDTH'(1);
                            end
                            if (mem_dir != DIR_UP) begin
                                col_nx = next_col - COL_BITS_WIDTH'(1);
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                if (!en_traceback) begin
                    state_nx   = S_IDLE;
                    valid_nx   = 1'b0;
                    last_nx    = 1'b0;
                    counter_nx = '0;
                end else if (slot_free) begin
                    finished_nx = 1'b1;
                    path_len_nx = {1'b0, counter};
                    state_nx    = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // A legal matrix can never produce more than MAX_STEPS steps.
    counter_no_saturate: assert property (
        @(posedge clk) disable iff (!rst_n) !(cnt_inc && (counter == CNT_MAX))
    );

endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit
//
// Directed bench for traceback_unit. A table of walk scenarios (max cell,
// score, back-pressure pattern, expected length, end position, finish cycle)
// is applied in a loop; the step sequence of each scenario is written into
// exp_q by hand and compared as steps are accepted. The abort/restart and
// ignored-start cases are written out as explicit sequences.

module tb_traceback_unit;

    localparam int RW     = 5;
    localparam int CW     = 5;
    localparam int SW     = 8;
    localparam int PW     = 6;
    localparam int SLOT_W = 2 + RW + CW + 1;
    localparam int BUDGET = 200;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] DIAG = 2'b01;
    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] LEFT = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_traceback = 1'b0;
    logic          start_of_traceback = 1'b0;
    logic [RW-1:0] max_row = '0;
    logic [CW-1:0] max_col = '0;
    logic [SW-1:0] max_score = '0;
    logic [1:0]    mem_dir;
    logic [RW-1:0] next_row;
    logic [CW-1:0] next_col;
    logic          finished;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_dir;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last;
    logic [PW:0]   path_len;

    // Matrix memory model: direction of the currently addressed cell.
    logic [1:0] dir_mem [0:31][0:31];
    assign mem_dir = dir_mem[next_row][next_col];

    traceback_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .en_traceback       (en_traceback),
        .start_of_traceback (start_of_traceback),
        .max_row            (max_row),
        .max_col            (max_col),
        .max_score          (max_score),
        .mem_dir            (mem_dir),
        .next_row           (next_row),
        .next_col           (next_col),
        .finished           (finished),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_dir            (out_dir),
        .out_row            (out_row),
        .out_col            (out_col),
        .out_last           (out_last),
        .path_len           (path_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [SLOT_W-1:0] exp_q[$];

    typedef struct {
        int            id;
        logic [RW-1:0] mrow;
        logic [CW-1:0] mcol;
        logic [SW-1:0] mscore;
        int            stall;
        int            exp_len;
        logic [RW-1:0] end_row;
        logic [CW-1:0] end_col;
        int            exp_fin;
    } case_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [SLOT_W-1:0] mk(input logic [1:0] d, input int r, input int c, input logic l);
        return {d, RW'(r), CW'(c), l};
    endfunction

    task automatic clear_mem();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                dir_mem[r][c] = STOP;
    endtask

    // Staircase from (n,n): UP at (r,r), LEFT at (r-1,r), down to (0,0),
    // where DIAG forces a final boundary step. 2n+1 steps in total.
    task automatic build_stair(input int n);
        for (int r = n; r >= 1; r--) begin
            dir_mem[r][r]   = UP;
            dir_mem[r-1][r] = LEFT;
            exp_q.push_back(mk(UP, r, r, 1'b0));
            exp_q.push_back(mk(LEFT, r - 1, r, 1'b0));
        end
        dir_mem[0][0] = DIAG;
        exp_q.push_back(mk(DIAG, 0, 0, 1'b1));
    endtask

    task automatic setup_case(input int id);
        case (id)
            0: begin
                dir_mem[3][3] = DIAG;
                dir_mem[2][2] = DIAG;
                exp_q.push_back(mk(DIAG, 3, 3, 1'b0));
                exp_q.push_back(mk(DIAG, 2, 2, 1'b0));
            end
            1: begin
                // Score 0: the stored direction must never be used.
                dir_mem[4][7] = DIAG;
            end
            2: begin
                dir_mem[0][2] = DIAG;
                exp_q.push_back(mk(DIAG, 0, 2, 1'b1));
            end
            3: begin
                // Walk ends on STOP at (0,0), so no step carries out_last.
                dir_mem[2][1] = UP;
                dir_mem[1][1] = LEFT;
                dir_mem[1][0] = UP;
                exp_q.push_back(mk(UP, 2, 1, 1'b0));
                exp_q.push_back(mk(LEFT, 1, 1, 1'b0));
                exp_q.push_back(mk(UP, 1, 0, 1'b0));
            end
            4: build_stair(31);
            5: build_stair(5);
            default: ;
        endcase
    endtask

    task automatic run_case(input case_t c);
        logic [SLOT_W-1:0] held;
        logic [SLOT_W-1:0] cur;
        logic held_ok;
        int   stall_left;
        int   first_valid;
        int   cyc;
        bit   done;
        held = '0;
        held_ok = 1'b0;
        stall_left = c.stall;
        first_valid = -1;
        done = 1'b0;
        clear_mem();
        exp_q.delete();
        setup_case(c.id);
        max_row = c.mrow;
        max_col = c.mcol;
        max_score = c.mscore;
        en_traceback = 1'b1;
        start_of_traceback = 1'b1;
        out_ready = (c.stall == 0);
        @(posedge clk); #1;
        start_of_traceback = 1'b0;
        cyc = 1;
        check($sformatf("c%0d load_row", c.id), next_row, c.mrow);
        check($sformatf("c%0d load_col", c.id), next_col, c.mcol);
        check($sformatf("c%0d load_valid", c.id), out_valid, 0);
        while (!done && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            cur = {out_dir, out_row, out_col, out_last};
            if (finished) begin
                done = 1'b1;
                check($sformatf("c%0d fin_cycle", c.id), cyc, c.exp_fin);
                check($sformatf("c%0d path_len", c.id), path_len, c.exp_len);
                check($sformatf("c%0d fin_valid", c.id), out_valid, 0);
                check($sformatf("c%0d steps_left", c.id), exp_q.size(), 0);
                check($sformatf("c%0d end_row", c.id), next_row, c.end_row);
                check($sformatf("c%0d end_col", c.id), next_col, c.end_col);
                if (c.exp_len > 0)
                    check($sformatf("c%0d first_valid_cycle", c.id), first_valid, 2);
            end else if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall_left > 0) begin
                    if (held_ok) check($sformatf("c%0d stall_hold", c.id), cur, held);
                    held = cur;
                    held_ok = 1'b1;
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL c%0d extra_step: got %0h expected no step", c.id, cur);
                    end else begin
                        check($sformatf("c%0d step", c.id), cur, exp_q.pop_front());
                    end
                    held_ok = 1'b0;
                    stall_left = c.stall;
                end
            end else begin
                out_ready = (c.stall == 0);
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL c%0d timeout: got no finished within %0d cycles, expected finished", c.id, BUDGET);
        end
        en_traceback = 1'b0;
        out_ready = 1'b0;
        if (done) begin
            @(posedge clk); #1;
            check($sformatf("c%0d fin_pulse_end", c.id), finished, 0);
            check($sformatf("c%0d path_len_clear", c.id), path_len, 0);
        end
    endtask

    case_t cases[5];
    case_t restart_case;

    initial begin
        logic [SLOT_W-1:0] cur;

        //      id  row  col  score stall len endr endc fin
        cases[0] = '{0,  3,   3,   9,   0,    2,  1,   1,  5};
        cases[1] = '{1,  4,   7,   0,   0,    0,  4,   7,  2};
        cases[2] = '{2,  0,   2,   9,   0,    1,  0,   2,  3};
        cases[3] = '{3,  2,   1,   6,   3,    3,  0,   0,  15};
        cases[4] = '{4,  31,  31,  200, 0,    63, 0,   0,  65};
        restart_case = '{5, 5, 5, 12, 0, 11, 0, 0, 13};

        clear_mem();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst next_row", next_row, 0);
        check("rst next_col", next_col, 0);
        check("rst out_valid", out_valid, 0);
        check("rst finished", finished, 0);
        check("rst slot", {out_dir, out_row, out_col, out_last}, 0);
        check("rst path_len", path_len, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start without en_traceback is ignored
        max_row = 5'd9;
        max_col = 5'd9;
        max_score = 8'd5;
        start_of_traceback = 1'b1;
        en_traceback = 1'b0;
        @(posedge clk); #1;
        start_of_traceback = 1'b0;
        check("noen next_row", next_row, 0);
        check("noen next_col", next_col, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("noen out_valid", out_valid, 0);
            check("noen finished", finished, 0);
        end

        for (int i = 0; i < 5; i++) begin
            run_case(cases[i]);
        end

        // Abort after two steps, then restart from a new max cell
        clear_mem();
        exp_q.delete();
        build_stair(31);
        max_row = 5'd31;
        max_col = 5'd31;
        max_score = 8'd50;
        en_traceback = 1'b1;
        start_of_traceback = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start_of_traceback = 1'b0;
        @(posedge clk); #1;
        cur = {out_dir, out_row, out_col, out_last};
        check("abort step1_valid", out_valid, 1);
        check("abort step1", cur, exp_q.pop_front());
        @(posedge clk); #1;
        cur = {out_dir, out_row, out_col, out_last};
        check("abort step2_valid", out_valid, 1);
        check("abort step2", cur, exp_q.pop_front());
        en_traceback = 1'b0;
        @(posedge clk); #1;
        check("abort out_valid", out_valid, 0);
        check("abort finished", finished, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort no_finish", finished, 0);
            check("abort path_len", path_len, 0);
        end
        run_case(restart_case);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
